ram_sp_burst_ctrl: RTL and testbench

- Initiator-side controller for the single-port synchronous RAM used by the LDPC decoder's message memories.
- Accepts burst commands from the decoder core and streams write data in.
- Sequences RAM cs/we/address with auto-increment and handles the RAM's 1-cycle registered read latency.
- Returns read data through a 2-entry response buffer with valid/ready backpressure.

---
 rtl/ram_ctrl_pkg.sv | 20 ++
 rtl/resp_fifo2.sv | 67 ++++++
 rtl/ram_sp_burst_ctrl.sv | 161 ++++++++++++++++
 tb/tb_ram_sp_burst_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_ctrl_pkg.sv
// Shared constants and helpers for the single-port RAM burst controller.
// Optional statistics counters are enabled with the RAM_BURST_STATS_EN macro.
package ram_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StWr   = 2'd1;
    localparam state_t StRd   = 2'd2;

    localparam int unsigned RD_LATENCY      = 1;
    localparam int unsigned RESP_FIFO_DEPTH = 2;
    localparam int unsigned STAT_CNT_WIDTH  = 32;

    // Saturating increment for the statistics counters.
    function automatic logic [STAT_CNT_WIDTH-1:0] sat_inc(input logic [STAT_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + STAT_CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry response FIFO holding {last, data} read beats for the burst controller.
// Push is accepted while full only when a pop happens in the same cycle.
module resp_fifo2
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic                  push_last_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic                  last_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o
);

    localparam logic [1:0] Full = 2'(RESP_FIFO_DEPTH);

    logic [DATA_WIDTH:0] mem_q [RESP_FIFO_DEPTH];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;
    logic [1:0]          count_d;
    logic                do_push;
    logic                do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != Full) || do_pop);

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RESP_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign last_o  = mem_q[rd_ptr_q][DATA_WIDTH];
    assign data_o  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign count_o = count_q;

endmodule

// File: rtl/ram_sp_burst_ctrl.sv
// Burst controller for a single-port synchronous RAM with 1-cycle registered reads.
// Define RAM_BURST_STATS_EN to add saturating write/read statistics counters.
module ram_sp_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
`ifdef RAM_BURST_STATS_EN
    output logic [STAT_CNT_WIDTH-1:0] stat_wr_cnt_o,
    output logic [STAT_CNT_WIDTH-1:0] stat_rd_cnt_o,
`endif
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]      cmd_len_i,
    input  logic                      wdat_valid_i,
    output logic                      wdat_ready_o,
    input  logic [DATA_WIDTH-1:0]     wdat_data_i,
    output logic                      rdat_valid_o,
    input  logic                      rdat_ready_i,
    output logic [DATA_WIDTH-1:0]     rdat_data_o,
    output logic                      rdat_last_o,
    output logic                      ram_cs_o,
    output logic                      ram_we_o,
    output logic [ADDR_WIDTH-1:0]     ram_address_o,
    output logic [DATA_WIDTH-1:0]     ram_data_in_o,
    input  logic [DATA_WIDTH-1:0]     ram_data_out_i
);

    localparam int unsigned OCC_W = $clog2(RESP_FIFO_DEPTH + RD_LATENCY + 1);
    localparam logic [OCC_W-1:0] IssueLimit = OCC_W'(RESP_FIFO_DEPTH);

    state_t                state_q;
    state_t                state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [LEN_WIDTH-1:0]  rem_d;
    logic                  infl_q;
    logic                  infl_last_q;

    logic                  issue;
    logic                  wr_beat;
    logic                  pop;
    logic [1:0]            fifo_count;
    logic [OCC_W-1:0]      occ;

    assign pop = rdat_valid_o && rdat_ready_i;
    // Slots already claimed once this cycle's pop is accounted for.
    assign occ = OCC_W'(fifo_count) + OCC_W'(infl_q) - OCC_W'(pop);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        issue        = 1'b0;
        wr_beat      = 1'b0;
        wdat_ready_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    rem_d   = cmd_len_i;
                    state_d = cmd_we_i ? StWr : StRd;
                end
            end
            StWr: begin
                wdat_ready_o = 1'b1;
                if (wdat_valid_i) begin
                    wr_beat = 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    if (rem_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        rem_d = rem_q - LEN_WIDTH'(1);
                    end
                end
            end
            StRd: begin
                if (occ < IssueLimit) begin
                    issue  = 1'b1;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    if (rem_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        rem_d = rem_q - LEN_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= issue;
            infl_last_q <= issue && (rem_q == '0);
        end
    end

    // IDLE is the reset state, but the handshake must stay low while reset is held.
    assign cmd_ready_o   = rst_n && (state_q == StIdle);
    assign ram_cs_o      = issue || wr_beat;
    assign ram_we_o      = wr_beat;
    assign ram_address_o = (issue || wr_beat) ? addr_q : '0;
    assign ram_data_in_o = wr_beat ? wdat_data_i : '0;

    resp_fifo2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_resp_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (infl_q),
        .push_last_i(infl_last_q),
        .push_data_i(ram_data_out_i),
        .pop_i      (pop),
        .valid_o    (rdat_valid_o),
        .last_o     (rdat_last_o),
        .data_o     (rdat_data_o),
        .count_o    (fifo_count)
    );

`ifdef RAM_BURST_STATS_EN
    logic [STAT_CNT_WIDTH-1:0] stat_wr_q;
    logic [STAT_CNT_WIDTH-1:0] stat_rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_q <= '0;
            stat_rd_q <= '0;
        end else begin
            if (wr_beat) begin
                stat_wr_q <= sat_inc(stat_wr_q);
            end
            if (pop) begin
                stat_rd_q <= sat_inc(stat_rd_q);
            end
        end
    end

    assign stat_wr_cnt_o = stat_wr_q;
    assign stat_rd_cnt_o = stat_rd_q;
`endif

endmodule

// File: tb/tb_ram_sp_burst_ctrl.sv
// Self-checking bench for ram_sp_burst_ctrl: directed burst table, reset corner case,
// and randomized bursts against a command-level memory model.
module tb_ram_sp_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_we = 1'b0;
    logic [7:0] cmd_addr = 8'h00;
    logic [3:0] cmd_len = 4'h0;
    logic       wdat_valid = 1'b0;
    logic       wdat_ready;
    logic [7:0] wdat_data = 8'h00;
    logic       rdat_valid;
    logic       rdat_ready = 1'b1;
    logic [7:0] rdat_data;
    logic       rdat_last;
    logic       ram_cs;
    logic       ram_we;
    logic [7:0] ram_address;
    logic [7:0] ram_data_in;
    logic [7:0] ram_data_out = 8'h00;
`ifdef RAM_BURST_STATS_EN
    logic [31:0] stat_wr_cnt;
    logic [31:0] stat_rd_cnt;
`endif

    ram_sp_burst_ctrl #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(8),
        .LEN_WIDTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef RAM_BURST_STATS_EN
        .stat_wr_cnt_o (stat_wr_cnt),
        .stat_rd_cnt_o (stat_rd_cnt),
`endif
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_addr_i    (cmd_addr),
        .cmd_len_i     (cmd_len),
        .wdat_valid_i  (wdat_valid),
        .wdat_ready_o  (wdat_ready),
        .wdat_data_i   (wdat_data),
        .rdat_valid_o  (rdat_valid),
        .rdat_ready_i  (rdat_ready),
        .rdat_data_o   (rdat_data),
        .rdat_last_o   (rdat_last),
        .ram_cs_o      (ram_cs),
        .ram_we_o      (ram_we),
        .ram_address_o (ram_address),
        .ram_data_in_o (ram_data_in),
        .ram_data_out_i(ram_data_out)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with registered read; no reset.
    logic [7:0] ram_mem [256];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) ram_mem[ram_address] <= ram_data_in;
            else        ram_data_out <= ram_mem[ram_address];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } acc_t;

    acc_t       exp_acc [$];
    logic [8:0] exp_rd  [$];
    logic [7:0] ref_mem [256];

    // Read-data consumer: drives rdat_ready and scores every handshake.
    int          rmode = 0;
    int unsigned pidx = 0;
    logic [3:0]  tog_pat = 4'b1001;
    int          hs_cnt = 0;
    int unsigned hs_first = 0;
    int unsigned hs_last = 0;
    int unsigned rd_pops = 0;
    logic        held = 1'b0;
    logic [8:0]  held_val = '0;
    logic [8:0]  cons_e;

    always @(negedge clk) begin
        case (rmode)
            0:       rdat_ready = 1'b1;
            1:       rdat_ready = tog_pat[pidx % 4];
            default: rdat_ready = ($urandom_range(0, 2) != 0);
        endcase
        pidx++;
        #1;
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held && rdat_valid) check("rd_stable_while_stalled", {rdat_last, rdat_data}, held_val);
            held = rdat_valid && !rdat_ready;
            held_val = {rdat_last, rdat_data};
            if (rdat_valid && rdat_ready) begin
                if (exp_rd.size() == 0) begin
                    check("rd_unexpected_beat", {rdat_last, rdat_data}, 32'hFFFF_FFFF);
                end else begin
                    cons_e = exp_rd.pop_front();
                    check("rd_data", rdat_data, cons_e[7:0]);
                    check("rd_last", rdat_last, cons_e[8]);
                end
                if (hs_cnt == 0) hs_first = cyc;
                hs_last = cyc;
                hs_cnt++;
                rd_pops++;
            end
        end
    end

    // RAM access monitor plus outstanding-read tracking.
    int unsigned issued = 0;
    int          max_out = 0;
    acc_t        mon_a;

    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            issued = 0;
            rd_pops = 0;
        end else if (ram_cs) begin
            if (exp_acc.size() == 0) begin
                check("acc_unexpected", {ram_we, ram_address}, 32'hFFFF_FFFF);
            end else begin
                mon_a = exp_acc.pop_front();
                check("acc_we", ram_we, mon_a.we);
                check("acc_addr", ram_address, mon_a.addr);
                if (mon_a.we) check("acc_wdata", ram_data_in, mon_a.data);
            end
            if (!ram_we) issued++;
        end
        if (int'(issued) - int'(rd_pops) > max_out) max_out = int'(issued) - int'(rd_pops);
    end

    task automatic send_cmd(input logic we, input logic [7:0] addr, input logic [3:0] len);
        int guard = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_len   = len;
        #1;
        while (!cmd_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("cmd_accept_in_time", guard < 200, 1);
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [3:0] len,
                            input logic [7:0] base, input logic directed);
        logic [7:0] wd [16];
        int i = 0;
        int guard = 0;
        for (int k = 0; k <= int'(len); k++) begin
            wd[k] = directed ? 8'(int'(base) + k) : 8'($urandom);
            exp_acc.push_back('{1'b1, 8'(int'(addr) + k), wd[k]});
            ref_mem[8'(int'(addr) + k)] = wd[k];
        end
        send_cmd(1'b1, addr, len);
        while (i <= int'(len) && guard < 100) begin
            @(negedge clk);
            cmd_valid  = 1'b0;
            wdat_valid = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
            wdat_data  = wd[i];
            #1;
            if (wdat_valid && wdat_ready) i++;
            guard++;
        end
        @(negedge clk);
        wdat_valid = 1'b0;
        #1;
        check("wr_beats_done", i, int'(len) + 1);
        if (directed) check("wr_beats_consecutive", guard, int'(len) + 1);
        check("wr_cmd_ready_after_last", cmd_ready, 1);
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [3:0] len,
                           input logic [7:0] base, input logic directed, input int mode);
        rmode = mode;
        pidx  = 0;
        for (int k = 0; k <= int'(len); k++) begin
            if (directed) exp_rd.push_back({k == int'(len), 8'(int'(base) + k)});
            else          exp_rd.push_back({k == int'(len), ref_mem[8'(int'(addr) + k)]});
            exp_acc.push_back('{1'b0, 8'(int'(addr) + k), 8'h00});
        end
        hs_cnt = 0;
        send_cmd(1'b0, addr, len);
        if (directed) begin
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                #3;
                if (k == 1) check("rd_first_access_T+1", ram_cs, 1);
                check("rd_valid_latency", rdat_valid, (k == 3));
            end
        end else begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_rd.size() != 0 || exp_acc.size() != 0 || !cmd_ready) && guard < 400) begin
            @(negedge clk);
            #3;
            guard++;
        end
        check("drain_in_time", guard < 400, 1);
    endtask

    typedef struct {
        logic       we;
        logic [7:0] addr;
        logic [3:0] len;
        logic [7:0] base;   // write data / expected read data of beat 0, +1 per beat
        int         mode;   // read consumer: 0 always ready, 1 toggling, 2 random
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{1'b1, 8'h10, 4'd3, 8'hA0, 0};
        vecs[1] = '{1'b0, 8'h10, 4'd3, 8'hA0, 0};
        vecs[2] = '{1'b0, 8'h10, 4'd3, 8'hA0, 1};
        vecs[3] = '{1'b1, 8'hFE, 4'd2, 8'h01, 0};
        vecs[4] = '{1'b0, 8'hFE, 4'd2, 8'h01, 2};

        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end

        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs_zero", {cmd_ready, wdat_ready, rdat_valid, rdat_last, ram_cs, ram_we,
                                     ram_address, ram_data_in, rdat_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_rdat_valid", rdat_valid, 0);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].we) begin
                do_write(vecs[v].addr, vecs[v].len, vecs[v].base, 1'b1);
            end else begin
                do_read(vecs[v].addr, vecs[v].len, vecs[v].base, 1'b1, vecs[v].mode);
            end
            wait_drain();
            if (!vecs[v].we) begin
                check("rd_beat_count", hs_cnt, int'(vecs[v].len) + 1);
                if (vecs[v].mode == 0) check("rd_sustained", hs_last - hs_first, vecs[v].len);
            end
`ifdef RAM_BURST_STATS_EN
            if (v == 1) begin
                check("stat_wr_cnt", stat_wr_cnt, 4);
                check("stat_rd_cnt", stat_rd_cnt, 4);
            end
`endif
        end

        // Reset in the middle of a long read burst.
        begin
            int guard = 0;
            rmode = 0;
            for (int k = 0; k < 16; k++) begin
                exp_rd.push_back({k == 15, ref_mem[8'(16 + k)]});
                exp_acc.push_back('{1'b0, 8'(16 + k), 8'h00});
            end
            hs_cnt = 0;
            send_cmd(1'b0, 8'h10, 4'hF);
            @(negedge clk);
            cmd_valid = 1'b0;
            while (hs_cnt < 2 && guard < 20) begin
                @(negedge clk);
                #2;
                guard++;
            end
            check("rst_burst_started", hs_cnt >= 2, 1);
            #1;
            rst_n = 1'b0;
            #1;
            check("rst_async_outputs_zero", {cmd_ready, wdat_ready, rdat_valid, rdat_last, ram_cs,
                                             ram_we, ram_address, ram_data_in, rdat_data}, 0);
            exp_rd.delete();
            exp_acc.delete();
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            #1;
            check("rst_release_cmd_ready", cmd_ready, 1);
            check("rst_release_rdat_valid", rdat_valid, 0);
            do_read(8'h10, 4'd0, 8'hA0, 1'b1, 0);
            wait_drain();
            check("rst_reread_beats", hs_cnt, 1);
        end

        // Randomized back-to-back bursts; reads may be accepted while data still drains.
        max_out = 0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) != 0)
                do_write(8'($urandom), 4'($urandom), 8'h00, 1'b0);
            else
                do_read(8'($urandom), 4'($urandom), 8'h00, 1'b0, $urandom_range(0, 2));
        end
        wait_drain();
        check("outstanding_never_above_2", max_out <= 2, 1);
        check("outstanding_reaches_2", max_out, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "timeout");
    end

endmodule
